// File: rtl/udp_pkg.sv
// Shared definitions for the UDP/IPv4 receive and transmit paths:
// protocol constants, header lengths and the one-hot receiver state encoding.
package udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          ETH_HEAD_LEN  = 14;
    localparam int          UDP_HEAD_LEN  = 8;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    // One-hot bit positions of the receiver states
    localparam int ST_IDLE     = 0;
    localparam int ST_PREAMBLE = 1;
    localparam int ST_ETH_HEAD = 2;
    localparam int ST_IP_HEAD  = 3;
    localparam int ST_UDP_HEAD = 4;
    localparam int ST_RX_DATA  = 5;
    localparam int ST_RX_END   = 6;
    localparam int ST_ERROR    = 7;

    typedef enum logic [7:0] {
        S_IDLE     = 8'(1 << ST_IDLE),
        S_PREAMBLE = 8'(1 << ST_PREAMBLE),
        S_ETH_HEAD = 8'(1 << ST_ETH_HEAD),
        S_IP_HEAD  = 8'(1 << ST_IP_HEAD),
        S_UDP_HEAD = 8'(1 << ST_UDP_HEAD),
        S_RX_DATA  = 8'(1 << ST_RX_DATA),
        S_RX_END   = 8'(1 << ST_RX_END),
        S_ERROR    = 8'(1 << ST_ERROR)
    } udp_rx_state_t;

    // Byte idx (0 = most significant) of a 48-bit field, wire order
    function automatic logic [7:0] sel_byte48(input logic [47:0] v, input logic [2:0] idx);
        logic [47:0] sh;
        sh = v << {idx, 3'b000};
        return sh[47:40];
    endfunction

    // Byte idx (0 = most significant) of a 32-bit field, wire order
    function automatic logic [7:0] sel_byte32(input logic [31:0] v, input logic [1:0] idx);
        logic [31:0] sh;
        sh = v << {idx, 3'b000};
        return sh[31:24];
    endfunction

endpackage

// File: rtl/udp_rx_if.sv
// GMII receive byte stream in, user payload words out.
// master: the receiver; slave: the side feeding GMII and sinking payload.
interface udp_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;

    modport master (
        input  gmii_rx_dv, gmii_rxd,
        output rec_en, rec_data, rec_pkt_done, rec_byte_num
    );

    modport slave (
        output gmii_rx_dv, gmii_rxd,
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num
    );
endinterface

// File: rtl/udp_rx_ip_csum.sv
// Byte-wise 16-bit ones-complement accumulator for the IPv4 header.
// Bytes pair up big-endian into words; each word is added with end-around
// carry, so sum is always folded. Only built with UDP_RX_IP_CSUM_EN.
module udp_rx_ip_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  data,
    output logic [15:0] sum
);
    logic        odd_reg;
    logic [7:0]  hi_reg;
    logic [16:0] add;

    assign add = {1'b0, sum} + {1'b0, hi_reg, data};

    // Hold the high byte, then fold the completed word into the running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            odd_reg <= 1'b0;
            hi_reg  <= '0;
        end else if (clear) begin
            sum     <= '0;
            odd_reg <= 1'b0;
            hi_reg  <= '0;
        end else if (valid) begin
            if (!odd_reg) hi_reg <= data;
            else          sum    <= add[15:0] + {15'd0, add[16]};
            odd_reg <= ~odd_reg;
        end
    end
endmodule

// File: rtl/udp_rx.sv
// GMII-side UDP/IPv4 receiver: preamble/SFD, Ethernet, IPv4 and UDP header
// parsing with MAC/IP/port filtering; payload out as big-endian 32-bit words.
// Optional feature macro: UDP_RX_IP_CSUM_EN enables IPv4 header checksum
// verification (decision lands one cycle after the last IP header byte).
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [15:0] ETH_TYPE = ETH_TYPE_IPV4,
    parameter logic [7:0]  IP_PROTO = IP_PROTO_UDP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] board_mac,
    input  logic [31:0] board_ip,
    input  logic [15:0] board_port,
    udp_rx_if.master    bus
);
    udp_rx_state_t state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        mac_ok_reg, mac_ok_next;
    logic        bcast_ok_reg, bcast_ok_next;
    logic [3:0]  ihl_reg, ihl_next;
    logic [7:0]  len_hi_reg, len_hi_next;
    logic [15:0] data_num_reg, data_num_next;
    logic [23:0] buf_reg, buf_next;
    logic        rec_en_reg, rec_en_next;
    logic [31:0] rec_data_reg, rec_data_next;
    logic        rec_pkt_done_reg, rec_pkt_done_next;
    logic [15:0] rec_byte_num_reg, rec_byte_num_next;
    logic        csum_fail;
    logic        dv;
    logic [7:0]  rxd;
    logic [31:0] word;
    logic        ip_last;

    assign dv   = bus.gmii_rx_dv;
    assign rxd  = bus.gmii_rxd;
    assign word = {buf_reg, rxd};
    // IHL is latched on IP byte 0, and IHL>=5 puts the last byte at index >=19
    assign ip_last = (cnt_reg >= 16'd19) && (cnt_reg == ({10'd0, ihl_reg, 2'b00} - 16'd1));

`ifdef UDP_RX_IP_CSUM_EN
    logic [15:0] ip_sum;
    logic        csum_pend_reg;

    udp_rx_ip_csum u_ip_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_reg != S_IP_HEAD),
        .valid (state_reg == S_IP_HEAD && dv),
        .data  (rxd),
        .sum   (ip_sum)
    );

    // Flag the first UDP header cycle, when the full IP header sum is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_pend_reg <= 1'b0;
        else        csum_pend_reg <= (state_reg == S_IP_HEAD) && (state_next == S_UDP_HEAD);
    end

    assign csum_fail = csum_pend_reg && (ip_sum != 16'hFFFF);
`else
    assign csum_fail = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            cnt_reg          <= '0;
            mac_ok_reg       <= 1'b0;
            bcast_ok_reg     <= 1'b0;
            ihl_reg          <= '0;
            len_hi_reg       <= '0;
            data_num_reg     <= '0;
            buf_reg          <= '0;
            rec_en_reg       <= 1'b0;
            rec_data_reg     <= '0;
            rec_pkt_done_reg <= 1'b0;
            rec_byte_num_reg <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            mac_ok_reg       <= mac_ok_next;
            bcast_ok_reg     <= bcast_ok_next;
            ihl_reg          <= ihl_next;
            len_hi_reg       <= len_hi_next;
            data_num_reg     <= data_num_next;
            buf_reg          <= buf_next;
            rec_en_reg       <= rec_en_next;
            rec_data_reg     <= rec_data_next;
            rec_pkt_done_reg <= rec_pkt_done_next;
            rec_byte_num_reg <= rec_byte_num_next;
        end
    end

    // Next-state, header checks and payload word assembly
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        mac_ok_next       = mac_ok_reg;
        bcast_ok_next     = bcast_ok_reg;
        ihl_next          = ihl_reg;
        len_hi_next       = len_hi_reg;
        data_num_next     = data_num_reg;
        buf_next          = buf_reg;
        rec_en_next       = 1'b0;
        rec_data_next     = rec_data_reg;
        rec_pkt_done_next = 1'b0;
        rec_byte_num_next = rec_byte_num_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (dv) begin
                    cnt_next   = '0;
                    state_next = (rxd == PREAMBLE_BYTE) ? S_PREAMBLE : S_ERROR;
                end
            end
            S_PREAMBLE: begin
                if (!dv) state_next = S_IDLE;
                else if (cnt_reg < 16'd6) begin
                    if (rxd == PREAMBLE_BYTE) cnt_next = cnt_reg + 16'd1;
                    else                      state_next = S_ERROR;
                end else if (rxd == SFD_BYTE) begin
                    state_next    = S_ETH_HEAD;
                    cnt_next      = '0;
                    mac_ok_next   = 1'b1;
                    bcast_ok_next = 1'b1;
                end else state_next = S_ERROR;
            end
            S_ETH_HEAD: begin
                if (!dv) state_next = S_IDLE;
                else begin
                    cnt_next = cnt_reg + 16'd1;
                    if (cnt_reg < 16'd6) begin
                        mac_ok_next   = mac_ok_reg && (rxd == sel_byte48(board_mac, cnt_reg[2:0]));
                        bcast_ok_next = bcast_ok_reg && (rxd == sel_byte48(BCAST_MAC, cnt_reg[2:0]));
                        if (!mac_ok_next && !bcast_ok_next) state_next = S_ERROR;
                    end else if (cnt_reg == 16'(ETH_HEAD_LEN - 2)) begin
                        if (rxd != ETH_TYPE[15:8]) state_next = S_ERROR;
                    end else if (cnt_reg == 16'(ETH_HEAD_LEN - 1)) begin
                        if (rxd != ETH_TYPE[7:0]) state_next = S_ERROR;
                        else begin
                            state_next = S_IP_HEAD;
                            cnt_next   = '0;
                        end
                    end
                end
            end
            S_IP_HEAD: begin
                if (!dv) state_next = S_IDLE;
                else begin
                    cnt_next = cnt_reg + 16'd1;
                    if (cnt_reg == 16'd0) begin
                        ihl_next = rxd[3:0];
                        if (rxd[7:4] != 4'h4 || rxd[3:0] < 4'd5) state_next = S_ERROR;
                    end else if (cnt_reg == 16'd9) begin
                        if (rxd != IP_PROTO) state_next = S_ERROR;
                    end else if (cnt_reg >= 16'd16 && cnt_reg <= 16'd19) begin
                        if (rxd != sel_byte32(board_ip, cnt_reg[1:0])) state_next = S_ERROR;
                    end
                    // Option bytes between 20 and IHL*4 fall through unchecked
                    if (ip_last && state_next == S_IP_HEAD) begin
                        state_next = S_UDP_HEAD;
                        cnt_next   = '0;
                    end
                end
            end
            S_UDP_HEAD: begin
                if (!dv) state_next = S_IDLE;
                else if (csum_fail) state_next = S_ERROR;
                else begin
                    cnt_next = cnt_reg + 16'd1;
                    if (cnt_reg == 16'd2) begin
                        if (rxd != board_port[15:8]) state_next = S_ERROR;
                    end else if (cnt_reg == 16'd3) begin
                        if (rxd != board_port[7:0]) state_next = S_ERROR;
                    end else if (cnt_reg == 16'd4) begin
                        len_hi_next = rxd;
                    end else if (cnt_reg == 16'd5) begin
                        if ({len_hi_reg, rxd} < 16'(UDP_HEAD_LEN)) state_next = S_ERROR;
                        else data_num_next = {len_hi_reg, rxd} - 16'(UDP_HEAD_LEN);
                    end else if (cnt_reg == 16'(UDP_HEAD_LEN - 1)) begin
                        cnt_next = '0;
                        if (data_num_reg == 16'd0) begin
                            // Empty payload: done with no data word
                            rec_pkt_done_next = 1'b1;
                            rec_byte_num_next = '0;
                            state_next        = S_RX_END;
                        end else state_next = S_RX_DATA;
                    end
                end
            end
            S_RX_DATA: begin
                if (!dv) state_next = S_IDLE;
                else begin
                    cnt_next = cnt_reg + 16'd1;
                    buf_next = word[23:0];
                    // Emit on every 4th byte, or on the last one left-justified
                    if (cnt_reg[1:0] == 2'd3 || cnt_next == data_num_reg) begin
                        rec_en_next   = 1'b1;
                        rec_data_next = word << {~cnt_reg[1:0], 3'b000};
                    end
                    if (cnt_next == data_num_reg) begin
                        rec_pkt_done_next = 1'b1;
                        rec_byte_num_next = data_num_reg;
                        state_next        = S_RX_END;
                    end
                end
            end
            S_RX_END, S_ERROR: begin
                if (!dv) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.rec_en       = rec_en_reg;
    assign bus.rec_data     = rec_data_reg;
    assign bus.rec_pkt_done = rec_pkt_done_reg;
    assign bus.rec_byte_num = rec_byte_num_reg;

endmodule
